// File: rtl/riscv_shared_dotp_arbiter.sv
// Round-robin arbiter sharing one pipelined dot-product unit among several cores.
// A tag pipeline tracks which core owns each in-flight operation so its result can be returned.
module riscv_shared_dotp_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    core_req_i,
  output logic [NUM_CORES-1:0]    core_gnt_o,
  input  logic [NUM_CORES*32-1:0] core_op_a_i,
  input  logic [NUM_CORES*32-1:0] core_op_b_i,
  input  logic [NUM_CORES*32-1:0] core_op_c_i,
  input  logic [NUM_CORES*2-1:0]  core_dot_signed_i,
  input  logic [NUM_CORES-1:0]    core_dot16_i,
  output logic [NUM_CORES-1:0]    core_rvalid_o,
  output logic [31:0]             core_result_o,
  output logic                    unit_valid_o,
  output logic [31:0]             unit_op_a_o,
  output logic [31:0]             unit_op_b_o,
  output logic [31:0]             unit_op_c_o,
  output logic [1:0]              unit_dot_signed_o,
  output logic                    unit_dot16_o,
  input  logic                    unit_ready_i,
  input  logic [31:0]             unit_result_i
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  typedef logic [IdxW-1:0] idx_t;

  idx_t               ptr_q, ptr_d;
  logic [LATENCY-1:0] tag_valid_q;
  idx_t               tag_idx_q [LATENCY];
  logic [31:0]        result_q;

  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] gnt;
  logic                 gnt_any;
  idx_t                 gnt_idx;
  logic                 ret;

  // The last stage is excluded: a core may be re-granted in its own return cycle.
  always_comb begin
    busy = '0;
    for (int s = 0; s < int'(LATENCY) - 1; s++) begin
      if (tag_valid_q[s]) busy[tag_idx_q[s]] = 1'b1;
    end
  end

  assign eligible = core_req_i & ~busy & {NUM_CORES{unit_ready_i & rst_n}};

  always_comb begin : arb
    int unsigned cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!gnt_any && eligible[idx_t'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_t'(cand);
      end
    end
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == idx_t'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    unit_op_a_o       = '0;
    unit_op_b_o       = '0;
    unit_op_c_o       = '0;
    unit_dot_signed_o = '0;
    unit_dot16_o      = 1'b0;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
      if (gnt[k]) begin
        unit_op_a_o       = core_op_a_i[32*k +: 32];
        unit_op_b_o       = core_op_b_i[32*k +: 32];
        unit_op_c_o       = core_op_c_i[32*k +: 32];
        unit_dot_signed_o = core_dot_signed_i[2*k +: 2];
        unit_dot16_o      = core_dot16_i[k];
      end
    end
  end

  assign ret = tag_valid_q[LATENCY-1] & unit_ready_i;

  always_comb begin
    core_rvalid_o = '0;
    if (ret) core_rvalid_o[tag_idx_q[LATENCY-1]] = 1'b1;
  end

  assign core_result_o = ret ? unit_result_i : result_q;
  assign core_gnt_o    = gnt;
  assign unit_valid_o  = gnt_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      tag_valid_q <= '0;
      result_q    <= '0;
      for (int s = 0; s < int'(LATENCY); s++) tag_idx_q[s] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (ret) result_q <= unit_result_i;
      // The tag pipeline freezes together with the unit pipeline.
      if (unit_ready_i) begin
        tag_valid_q[0] <= gnt_any;
        tag_idx_q[0]   <= gnt_idx;
        for (int s = 1; s < int'(LATENCY); s++) begin
          tag_valid_q[s] <= tag_valid_q[s-1];
          tag_idx_q[s]   <= tag_idx_q[s-1];
        end
      end
    end
  end

endmodule
